// File: rtl/adder_pkg.sv
// Shared helpers for the adder family: chunk sizing, record layout constants and the
// WIDTH/STAGES legality check used by the RCA and future CLA/CSA variants.
`ifndef ADDER_PKG_SV
`define ADDER_PKG_SV

// Elaboration-time guard: WIDTH must split evenly into at least one stage.
`define ADDER_CHECK_STAGES(W, S) \
    if ((S) < 1 || ((W) % (S)) != 0) begin : g_bad_cfg \
        $error("adder: WIDTH must be a positive multiple of STAGES"); \
    end

package adder_pkg;

    // Per-stage record: valid bit, carry bit, then sum and skewed operand fields.
    localparam int unsigned STAGE_VALID_W = 1;
    localparam int unsigned STAGE_CARRY_W = 1;

    function automatic int unsigned chunk_width(input int unsigned width,
                                                input int unsigned stages);
        return (stages == 0) ? width : width / stages;
    endfunction

endpackage

`endif

// File: rtl/pipelined_rca_if.sv
// Operand/result valid-ready bundle for pipelined_rca.
// The ovf signal exists only when ADDER_OVF_EN is defined.
interface pipelined_rca_if #(
    parameter int unsigned WIDTH = 64
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
`ifdef ADDER_OVF_EN
    logic             ovf;
`endif

    modport master (
        output in_valid, a, b, cin, out_ready,
        input  in_ready, out_valid, sum, cout
`ifdef ADDER_OVF_EN
        , ovf
`endif
    );

    modport slave (
        input  in_valid, a, b, cin, out_ready,
        output in_ready, out_valid, sum, cout
`ifdef ADDER_OVF_EN
        , ovf
`endif
    );
endinterface

// File: rtl/rca_chunk.sv
// Combinational CHUNK-bit ripple of full adders; one instance per pipeline stage.
module rca_chunk #(
    parameter int unsigned CHUNK = 16
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             cin,
    output logic [CHUNK-1:0] sum,
    output logic             cout
);
    always_comb begin
        logic carry;
        carry = cin;
        sum   = '0;
        for (int i = 0; i < int'(CHUNK); i++) begin
            sum[i] = a[i] ^ b[i] ^ carry;
            carry  = (a[i] & b[i]) | (carry & (a[i] ^ b[i]));
        end
        cout = carry;
    end
endmodule

// File: rtl/pipelined_rca.sv
// Pipelined ripple-carry adder: {cout,sum} = a + b + cin over STAGES registered chunks.
// Define ADDER_OVF_EN to add the registered signed-overflow output.
module pipelined_rca
    import adder_pkg::*;
#(
    parameter int unsigned WIDTH  = 64,
    parameter int unsigned STAGES = 4
) (
    input logic            clk,
    input logic            rst_n,
    pipelined_rca_if.slave bus
);
    localparam int unsigned CHUNK = chunk_width(WIDTH, STAGES);
    localparam int          LAST  = int'(STAGES) - 1;

    `ADDER_CHECK_STAGES(WIDTH, STAGES)

    // Stage k registers: op valid, finished low sum bits, carry out of chunk k, and the
    // operand bits still to be added, shifted down so the next chunk sits at bit 0.
    logic             vld_q [STAGES];
    logic [WIDTH-1:0] sum_q [STAGES];
    logic             cry_q [STAGES];
    logic [WIDTH-1:0] opa_q [STAGES];
    logic [WIDTH-1:0] opb_q [STAGES];

    logic             in_vld [STAGES];
    logic [WIDTH-1:0] in_a   [STAGES];
    logic [WIDTH-1:0] in_b   [STAGES];
    logic             in_c   [STAGES];
    logic [WIDTH-1:0] in_sum [STAGES];
    logic [WIDTH-1:0] sum_d  [STAGES];
    logic [CHUNK-1:0] cs     [STAGES];
    logic             co     [STAGES];
    logic             adv;

    // The whole pipe moves together; it freezes only while the result is refused.
    assign adv          = bus.out_ready | ~vld_q[LAST];
    assign bus.in_ready = adv;

    always_comb begin
        in_vld[0] = bus.in_valid;
        in_a[0]   = bus.a;
        in_b[0]   = bus.b;
        in_c[0]   = bus.cin;
        in_sum[0] = '0;
        for (int k = 1; k < int'(STAGES); k++) begin
            in_vld[k] = vld_q[k-1];
            in_a[k]   = opa_q[k-1];
            in_b[k]   = opb_q[k-1];
            in_c[k]   = cry_q[k-1];
            in_sum[k] = sum_q[k-1];
        end
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        rca_chunk #(
            .CHUNK (CHUNK)
        ) u_chunk (
            .a    (in_a[k][CHUNK-1:0]),
            .b    (in_b[k][CHUNK-1:0]),
            .cin  (in_c[k]),
            .sum  (cs[k]),
            .cout (co[k])
        );
    end

    always_comb begin
        for (int k = 0; k < int'(STAGES); k++) begin
            sum_d[k]                    = in_sum[k];
            sum_d[k][k*CHUNK +: CHUNK]  = cs[k];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < int'(STAGES); k++) begin
                vld_q[k] <= 1'b0;
                sum_q[k] <= '0;
                cry_q[k] <= 1'b0;
                opa_q[k] <= '0;
                opb_q[k] <= '0;
            end
        end else if (adv) begin
            for (int k = 0; k < int'(STAGES); k++) begin
                vld_q[k] <= in_vld[k];
                sum_q[k] <= sum_d[k];
                cry_q[k] <= co[k];
                // The last stage has no upper operand bits left to forward.
                if (k < LAST) begin
                    opa_q[k] <= in_a[k] >> CHUNK;
                    opb_q[k] <= in_b[k] >> CHUNK;
                end
            end
        end
    end

    assign bus.out_valid = vld_q[LAST];
    assign bus.sum       = sum_q[LAST];
    assign bus.cout      = cry_q[LAST];

`ifdef ADDER_OVF_EN
    // After the skew shifts the operand MSBs sit at the top of the last chunk.
    logic ovf_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
        end else if (adv) begin
            ovf_q <= (in_a[LAST][CHUNK-1] == in_b[LAST][CHUNK-1]) &
                     (cs[LAST][CHUNK-1] != in_a[LAST][CHUNK-1]);
        end
    end

    assign bus.ovf = ovf_q;
`endif

endmodule

// File: tb/tb_pipelined_rca.sv
// Directed self-checking bench for pipelined_rca with STAGES = 1, 4 and 8 instances.
// Checks ovf as well when built with ADDER_OVF_EN.
module tb_pipelined_rca;
    localparam int unsigned W = 64;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    pipelined_rca_if #(.WIDTH(W)) if1 ();
    pipelined_rca_if #(.WIDTH(W)) if4 ();
    pipelined_rca_if #(.WIDTH(W)) if8 ();

    pipelined_rca #(.WIDTH(W), .STAGES(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));
    pipelined_rca #(.WIDTH(W), .STAGES(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(if4));
    pipelined_rca #(.WIDTH(W), .STAGES(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(if8));

    int          n_asserts = 0;
    int          n_fail    = 0;
    int          cyc       = 0;
    int          n_out     = 0;
    int          n_extra   = 0;
    int          first_out = -1;
    int          last_out  = -1;
    logic [64:0] exp_q [$];

    logic [W-1:0] va [8];
    logic [W-1:0] vb [8];
    logic         vc [8];

    task automatic check(input string tag, input logic [64:0] obs, input logic [64:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One cycle on the STAGES=4 instance, entered and left at a falling edge.
    task automatic step(input logic v, input logic [W-1:0] av, input logic [W-1:0] bv,
                        input logic cv, input logic ordy, output logic acc);
        logic [64:0] e;
        if4.in_valid  = v;
        if4.a         = av;
        if4.b         = bv;
        if4.cin       = cv;
        if4.out_ready = ordy;
        #1;
        if (if4.out_valid && ordy) begin
            if (exp_q.size() == 0) begin
                n_extra++;
            end else begin
                e = exp_q.pop_front();
                check("result_in_order", {if4.cout, if4.sum}, e);
            end
            n_out++;
            if (first_out < 0) first_out = cyc;
            last_out = cyc;
        end
        acc = v && if4.in_ready;
        if (acc) exp_q.push_back({1'b0, av} + {1'b0, bv} + {64'd0, cv});
        @(negedge clk);
        cyc++;
    endtask

    // Issue one op to all three depths and record when and what each presents.
    task automatic lat_vec(input string tag, input logic [W-1:0] av, input logic [W-1:0] bv,
                           input logic cv, input logic [W-1:0] es, input logic ec,
                           input logic eo);
        int          l1, l4, l8;
        logic [64:0] r1, r4, r8;
`ifdef ADDER_OVF_EN
        logic        o1, o4, o8;
`endif
        l1 = 0; l4 = 0; l8 = 0;
        r1 = '0; r4 = '0; r8 = '0;
        if1.a = av; if1.b = bv; if1.cin = cv; if1.in_valid = 1'b1; if1.out_ready = 1'b1;
        if4.a = av; if4.b = bv; if4.cin = cv; if4.in_valid = 1'b1; if4.out_ready = 1'b1;
        if8.a = av; if8.b = bv; if8.cin = cv; if8.in_valid = 1'b1; if8.out_ready = 1'b1;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            if1.in_valid = 1'b0;
            if4.in_valid = 1'b0;
            if8.in_valid = 1'b0;
            if (l1 == 0 && if1.out_valid) begin
                l1 = c; r1 = {if1.cout, if1.sum};
`ifdef ADDER_OVF_EN
                o1 = if1.ovf;
`endif
            end
            if (l4 == 0 && if4.out_valid) begin
                l4 = c; r4 = {if4.cout, if4.sum};
`ifdef ADDER_OVF_EN
                o4 = if4.ovf;
`endif
            end
            if (l8 == 0 && if8.out_valid) begin
                l8 = c; r8 = {if8.cout, if8.sum};
`ifdef ADDER_OVF_EN
                o8 = if8.ovf;
`endif
            end
        end
        check({tag, "_lat_s1"}, 65'(l1), 65'd1);
        check({tag, "_lat_s4"}, 65'(l4), 65'd4);
        check({tag, "_lat_s8"}, 65'(l8), 65'd8);
        check({tag, "_res_s1"}, r1, {ec, es});
        check({tag, "_res_s4"}, r4, {ec, es});
        check({tag, "_res_s8"}, r8, {ec, es});
`ifdef ADDER_OVF_EN
        check({tag, "_ovf_s1"}, 65'(o1), 65'(eo));
        check({tag, "_ovf_s4"}, 65'(o4), 65'(eo));
        check({tag, "_ovf_s8"}, 65'(o8), 65'(eo));
`else
        if (eo) begin end
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic        acc;
        int          n_acc;
        logic [64:0] held;

        va[0] = 64'd1;                  vb[0] = 64'd2;                  vc[0] = 1'b0;
        va[1] = 64'hFFFF_FFFF_FFFF_FFFF; vb[1] = 64'hFFFF_FFFF_FFFF_FFFF; vc[1] = 1'b1;
        va[2] = 64'h0123_4567_89AB_CDEF; vb[2] = 64'hFEDC_BA98_7654_3210; vc[2] = 1'b0;
        va[3] = 64'h8000_0000_0000_0000; vb[3] = 64'h8000_0000_0000_0000; vc[3] = 1'b0;
        va[4] = 64'h0000_0000_FFFF_FFFF; vb[4] = 64'd1;                  vc[4] = 1'b0;
        va[5] = 64'hDEAD_BEEF_CAFE_F00D; vb[5] = 64'h1234_5678_9ABC_DEF0; vc[5] = 1'b1;
        va[6] = 64'd0;                  vb[6] = 64'd0;                  vc[6] = 1'b1;
        va[7] = 64'hFFFF_0000_FFFF_0000; vb[7] = 64'h0001_0000_0001_0000; vc[7] = 1'b0;

        rst_n = 1'b0;
        if1.in_valid = 1'b0; if1.a = '0; if1.b = '0; if1.cin = 1'b0; if1.out_ready = 1'b1;
        if4.in_valid = 1'b0; if4.a = '0; if4.b = '0; if4.cin = 1'b0; if4.out_ready = 1'b1;
        if8.in_valid = 1'b0; if8.a = '0; if8.b = '0; if8.cin = 1'b0; if8.out_ready = 1'b1;
        repeat (2) @(negedge clk);

        check("rst_out_valid", 65'(if4.out_valid), 65'd0);
        check("rst_sum_cout", {if4.cout, if4.sum}, 65'd0);
        check("rst_in_ready", 65'(if4.in_ready), 65'd1);
        check("rst_out_valid_s8", 65'(if8.out_valid), 65'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Directed latency/result vectors on all three depths.
        lat_vec("add_7_3", 64'd7, 64'd3, 1'b0, 64'd10, 1'b0, 1'b0);
        lat_vec("carry_all", 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b1, 64'd0, 1'b1, 1'b0);
        lat_vec("carry_part", 64'h0000_FFFF_0000_FFFF, 64'd1, 1'b1,
                64'h0000_FFFF_0001_0001, 1'b0, 1'b0);
        lat_vec("ovf_pos", 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0,
                64'h8000_0000_0000_0000, 1'b0, 1'b1);

        // Back-to-back stream with no backpressure.
        exp_q.delete(); n_out = 0; n_extra = 0; first_out = -1; last_out = -1;
        for (int i = 0; i < 8; i++) begin
            step(1'b1, va[i], vb[i], vc[i], 1'b1, acc);
            check("b2b_accept", 65'(acc), 65'd1);
        end
        for (int i = 0; i < 10; i++) step(1'b0, '0, '0, 1'b0, 1'b1, acc);
        check("b2b_count", 65'(n_out), 65'd8);
        check("b2b_consecutive", 65'(last_out - first_out), 65'd7);
        check("b2b_leftover", 65'(exp_q.size()), 65'd0);
        check("b2b_extra", 65'(n_extra), 65'd0);

        // Fill under backpressure, hold five cycles, then drain with new ops overlapping.
        exp_q.delete(); n_out = 0; n_extra = 0; n_acc = 0;
        for (int i = 0; i < 6; i++) begin
            step(1'b1, va[(i + 3) % 8], vb[(i + 3) % 8], vc[(i + 3) % 8], 1'b0, acc);
            if (acc) n_acc++;
        end
        check("bp_fill_accepted", 65'(n_acc), 65'd4);
        check("bp_out_valid", 65'(if4.out_valid), 65'd1);
        held = {if4.cout, if4.sum};
        check("bp_head_value", held, {1'b0, va[3]} + {1'b0, vb[3]} + {64'd0, vc[3]});
        for (int i = 0; i < 5; i++) begin
            step(1'b1, va[0], vb[0], vc[0], 1'b0, acc);
            check("bp_in_ready_low", 65'(acc), 65'd0);
            check("bp_out_valid_held", 65'(if4.out_valid), 65'd1);
            check("bp_result_held", {if4.cout, if4.sum}, held);
        end
        for (int i = 0; i < 2; i++) begin
            step(1'b1, va[i + 5], vb[i + 5], vc[i + 5], 1'b1, acc);
            check("bp_overlap_accept", 65'(acc), 65'd1);
        end
        for (int i = 0; i < 10; i++) step(1'b0, '0, '0, 1'b0, 1'b1, acc);
        check("bp_drain_count", 65'(n_out), 65'd6);
        check("bp_leftover", 65'(exp_q.size()), 65'd0);
        check("bp_extra", 65'(n_extra), 65'd0);

        // Asynchronous reset with the pipe full: results vanish without a clock edge.
        for (int i = 0; i < 5; i++) step(1'b1, va[i], vb[i], vc[i], 1'b0, acc);
        check("pre_rst_out_valid", 65'(if4.out_valid), 65'd1);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_out_valid", 65'(if4.out_valid), 65'd0);
        check("async_rst_sum_cout", {if4.cout, if4.sum}, 65'd0);
        check("async_rst_in_ready", 65'(if4.in_ready), 65'd1);
        exp_q.delete(); n_out = 0; n_extra = 0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) step(1'b0, '0, '0, 1'b0, 1'b1, acc);
        check("post_rst_no_output", 65'(n_out), 65'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end
endmodule
